pwm_regfile: RTL and testbench

PWM_REGFILE -- requirements
Module: pwm_regfile

---
 rtl/pwm_regfile.sv | 134 +++++++++++++
 tb/tb_pwm_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_regfile.sv
// pwm_regfile: four-register PWM block fed by an SPI slave.
//   addr 0 CTRL (bit0 EN, bit1 POL), 1 PRESC, 2 PERIOD, 3 DUTY.
// Writes are edge-triggered on wr_en; reads are combinational.
// Optional feature macro: PWM_SHADOW_EN -- when defined, PERIOD/DUTY
// changes made while running are applied only at the period wrap.
module pwm_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] addr_reg,
  input  logic [7:0] data_wr,
  input  logic       wr_en,
  output logic [7:0] data_rd_o,
  output logic       pwm_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q;
  logic       wr_q;       // previous-cycle wr_en
  logic       arm_q;      // set once wr_en has been seen low after reset
  logic [1:0] ctrl_q;
  logic [7:0] presc_q, period_q, duty_q;
  logic [7:0] presc_cnt_q, cnt_q;
  logic       pwm_q;

  logic [7:0] period_act, duty_act;
  logic [7:0] presc_cnt_d, cnt_d;
  logic       tick, wrap, active, wr_pulse;

  // A write needs a genuine low->high edge; a level held across reset
  // release is not an edge because arm_q is still clear.
  assign wr_pulse = wr_en & ~wr_q & arm_q;

  // Programmed registers and write-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      arm_q    <= 1'b0;
      ctrl_q   <= 2'b00;
      presc_q  <= 8'h00;
      period_q <= 8'hFF;
      duty_q   <= 8'h80;
    end else begin
      wr_q <= wr_en;
      if (!wr_en) arm_q <= 1'b1;
      if (wr_pulse) begin
        case (addr_reg)
          2'd0:    ctrl_q   <= data_wr[1:0];
          2'd1:    presc_q  <= data_wr;
          2'd2:    period_q <= data_wr;
          default: duty_q   <= data_wr;
        endcase
      end
    end
  end

  // Readback always returns the programmed value, never the active copy
  always_comb begin
    data_rd_o = 8'h00;
    case (addr_reg)
      2'd0:    data_rd_o = {6'b0, ctrl_q};
      2'd1:    data_rd_o = presc_q;
      2'd2:    data_rd_o = period_q;
      default: data_rd_o = duty_q;
    endcase
  end

  // Prescaler tick, period counter next state and compare
  always_comb begin
    tick = (presc_cnt_q == presc_q);
    // >= also covers a PRESC lowered below the running count: clear, no tick
    presc_cnt_d = (presc_cnt_q >= presc_q) ? 8'h00 : presc_cnt_q + 8'd1;
    // >= lets a shrunken PERIOD pull an overshooting count back to 0
    wrap  = tick && (cnt_q >= period_act);
    cnt_d = cnt_q;
    if (tick) cnt_d = wrap ? 8'h00 : cnt_q + 8'd1;
    active = (cnt_q < duty_act);
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] period_act_q, duty_act_q;

  // Active copies track the registers while idle, reload only at wrap when running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_act_q <= 8'hFF;
      duty_act_q   <= 8'h80;
    end else if (state_q == IDLE || wrap) begin
      period_act_q <= period_q;
      duty_act_q   <= duty_q;
    end
  end

  assign period_act = period_act_q;
  assign duty_act   = duty_act_q;
`else
  assign period_act = period_q;
  assign duty_act   = duty_q;
`endif

  // IDLE/RUN sequencer owning the counters and the registered output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_cnt_q <= 8'h00;
      cnt_q       <= 8'h00;
      pwm_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_cnt_q <= 8'h00;
          cnt_q       <= 8'h00;
          pwm_q       <= ctrl_q[1];
          if (ctrl_q[0]) state_q <= RUN;
        end
        default: begin
          if (!ctrl_q[0]) begin
            state_q     <= IDLE;
            presc_cnt_q <= 8'h00;
            cnt_q       <= 8'h00;
            pwm_q       <= ctrl_q[1];
          end else begin
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            pwm_q       <= active ^ ctrl_q[1];
          end
        end
      endcase
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_regfile.sv
// Scoreboard bench for pwm_regfile: stimulus pushes expected values,
// a negedge monitor pops and compares against data_rd_o or pwm_out.
module tb_pwm_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] addr_reg = 2'd0;
  logic [7:0] data_wr = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] data_rd_o;
  logic       pwm_out;

  pwm_regfile dut (
    .clk(clk), .rst_n(rst_n), .addr_reg(addr_reg), .data_wr(data_wr),
    .wr_en(wr_en), .data_rd_o(data_rd_o), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         is_pwm;
    logic [7:0] v;
  } exp_t;

  exp_t sb_q[$];
  bit   chk_vld = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: one comparison per flagged negedge
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (chk_vld) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_empty: output presented with no expected value");
        end else begin
          e   = sb_q.pop_front();
          act = e.is_pwm ? {7'b0, pwm_out} : data_rd_o;
          if (act !== e.v) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", e.nm, act, e.v, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  // One slot = negedge+1 to the next negedge+1, containing one posedge
  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input bit is_pwm, input logic [7:0] v);
    exp_t e;
    e.nm = nm; e.is_pwm = is_pwm; e.v = v;
    sb_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [7:0] v);
    addr_reg = a;
    chk(nm, 1'b0, v);
  endtask

  // Write lands at the posedge of the first slot
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr_reg = a; data_wr = d; wr_en = 1'b1;
    slot();
    wr_en = 1'b0;
    slot();
  endtask

  initial begin
    slot();
    // Reset with wr_en held high across release
    addr_reg = 2'd3; data_wr = 8'h55; wr_en = 1'b1;
    slot();
    chk("pwm_in_rst", 1'b1, 8'h00);
    rst_n = 1'b1;
    repeat (3) slot();
    rd("wr_across_rst", 2'd3, 8'h80);
    wr_en = 1'b0;
    slot();

    rd("rst_ctrl", 2'd0, 8'h00);
    rd("rst_presc", 2'd1, 8'h00);
    rd("rst_period", 2'd2, 8'hFF);
    rd("rst_duty", 2'd3, 8'h80);
    chk("rst_pwm", 1'b1, 8'h00);

    // Long wr_en pulse with data changing mid-pulse: one write only
    addr_reg = 2'd3; data_wr = 8'h10; wr_en = 1'b1;
    repeat (10) slot();
    data_wr = 8'h20;
    repeat (10) slot();
    wr_en = 1'b0;
    slot();
    rd("single_write", 2'd3, 8'h10);

    wr(2'd1, 8'h00);
    wr(2'd2, 8'h09);
    wr(2'd3, 8'h03);
    rd("rb_period", 2'd2, 8'h09);
    rd("rb_duty", 2'd3, 8'h03);

    // Reserved CTRL bits read as zero; POL alone sets the idle level
    wr(2'd0, 8'hFE);
    rd("ctrl_rsvd", 2'd0, 8'h02);
    chk("idle_pol1", 1'b1, 8'h01);
    wr(2'd0, 8'h00);
    chk("idle_pol0", 1'b1, 8'h00);

    // PRESC=0 PERIOD=9 DUTY=3: 3 high / 7 low
    wr(2'd0, 8'h01);
    for (int i = 0; i < 20; i++) chk("run_pol0", 1'b1, ((i % 10) < 3) ? 8'h01 : 8'h00);

    wr(2'd0, 8'h00);
    chk("idle_lvl", 1'b1, 8'h00);
    wr(2'd0, 8'h03);
    for (int i = 0; i < 20; i++) chk("run_pol1", 1'b1, ((i % 10) < 3) ? 8'h00 : 8'h01);

    wr(2'd0, 8'h02);
    for (int i = 0; i < 10; i++) chk("pol_only", 1'b1, 8'h01);

    // PRESC=3 PERIOD=4 DUTY=2: 20-clk period, 8 high
    wr(2'd1, 8'h03);
    wr(2'd2, 8'h04);
    wr(2'd3, 8'h02);
    wr(2'd0, 8'h01);
    for (int i = 0; i < 40; i++) chk("presc_period", 1'b1, ((i % 20) < 8) ? 8'h01 : 8'h00);

    wr(2'd0, 8'h00);
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h01);
    for (int i = 0; i < 20; i++) chk("duty_gt_per", 1'b1, 8'h01);

    wr(2'd0, 8'h00);
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h01);
    for (int i = 0; i < 20; i++) chk("duty_zero", 1'b1, 8'h00);

    // DUTY 3 -> 6 written while cnt=1
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h09);
    wr(2'd3, 8'h03);
    wr(2'd0, 8'h01);
    chk("duty_upd_pre", 1'b1, 8'h01);
    wr(2'd3, 8'h06);
    for (int i = 3; i < 20; i++) begin
`ifdef PWM_SHADOW_EN
      chk("duty_upd_shadow", 1'b1, (i < 10) ? 8'h00 : (((i % 10) < 6) ? 8'h01 : 8'h00));
`else
      chk("duty_upd_direct", 1'b1, ((i % 10) < 6) ? 8'h01 : 8'h00);
`endif
    end

    // Reset mid-period
    rst_n = 1'b0;
    chk("rst_mid_pwm", 1'b1, 8'h00);
    rst_n = 1'b1;
    rd("rst_mid_duty", 2'd3, 8'h80);
    rd("rst_mid_ctrl", 2'd0, 8'h00);
    chk("rst_mid_idle", 1'b1, 8'h00);

    slot();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
